// File: rtl/byte_lane_mem.sv
// Multi-word byte-addressable store: each word is written serially one byte lane per
// cycle from a latched word-wide request; bytes are read back one per cycle with a registered port.
module byte_lane_mem #(
   parameter int unsigned BYTES_PER_WORD = 4,
   parameter int unsigned DEPTH          = 4,
   parameter bit          BIG_ENDIAN     = 1'b1,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned BW = $clog2(BYTES_PER_WORD),
   localparam int unsigned WW = 8 * BYTES_PER_WORD
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WW-1:0]    wr_data,
   output logic             wr_busy,
   output logic             wr_done,
   input  logic             rd,
   input  logic [AW-1:0]    rd_addr,
   input  logic [BW-1:0]    rd_sel,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             rd_err,
   output logic [DEPTH-1:0] word_valid,
   input  logic             clr_valid
);

   localparam logic [BW-1:0] LAST_LANE = BW'(BYTES_PER_WORD - 1);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   lane_q, lane_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [WW-1:0]   data_q, data_d;
   logic            busy_d, done_d;
   logic [DEPTH-1:0] valid_d;
   logic            mem_we_c;
   logic [7:0]      wr_byte_c;
   logic [31:0]     byte_idx_c;
   logic            wr_addr_ok_c;
   logic            rd_ok_c;

   logic [7:0] mem [DEPTH][BYTES_PER_WORD];

   assign wr_addr_ok_c = (32'(wr_addr) < DEPTH);
   assign rd_ok_c      = (32'(rd_addr) < DEPTH) && (32'(rd_sel) < BYTES_PER_WORD)
                         && word_valid[rd_addr];

   // Byte index 0 is the MSB of the word when big-endian, the LSB otherwise.
   always_comb begin
      byte_idx_c = 32'(lane_q);
      if (BIG_ENDIAN) byte_idx_c = BYTES_PER_WORD - 1 - 32'(lane_q);
      wr_byte_c = 8'(data_q >> (8 * byte_idx_c));
   end

   // Write sequencer next-state and flag updates; a set on completion overrides clr_valid.
   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      addr_d   = addr_q;
      data_d   = data_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      valid_d  = word_valid;
      mem_we_c = 1'b0;
      if (clr_valid) valid_d = '0;
      case (state_q)
         IDLE: begin
            if (wr && wr_addr_ok_c) begin
               addr_d           = wr_addr;
               data_d           = wr_data;
               lane_d           = '0;
               valid_d[wr_addr] = 1'b0;
               busy_d           = 1'b1;
               state_d          = WRITE;
            end
         end
         WRITE: begin
            mem_we_c = 1'b1;
            busy_d   = 1'b1;
            lane_d   = BW'(lane_q + BW'(1));
            if (lane_q == LAST_LANE) begin
               valid_d[addr_q] = 1'b1;
               done_d          = 1'b1;
               busy_d          = 1'b0;
               lane_d          = '0;
               state_d         = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lane_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         wr_busy    <= 1'b0;
         wr_done    <= 1'b0;
         word_valid <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         wr_busy    <= busy_d;
         wr_done    <= done_d;
         word_valid <= valid_d;
      end
   end

   // Storage array is intentionally not reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[addr_q][lane_q] <= wr_byte_c;
   end

   // Registered read port; validity is taken from the flag value before this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else if (rd) begin
         if (rd_ok_c) begin
            rd_data  <= mem[rd_addr][rd_sel];
            rd_valid <= 1'b1;
            rd_err   <= 1'b0;
         end else begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b1;
         end
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_byte_lane_mem.sv
// Directed bench for byte_lane_mem: default 4x32 big-endian instance plus a
// 16x64 little-endian instance, with hand-computed expectations.
module tb_byte_lane_mem;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Instance A: BYTES_PER_WORD=4, DEPTH=4, BIG_ENDIAN=1
   logic        wr_a, rd_a, clr_a;
   logic [1:0]  wr_addr_a, rd_addr_a, rd_sel_a;
   logic [31:0] wr_data_a;
   logic        busy_a, done_a, rvalid_a, rerr_a;
   logic [7:0]  rdata_a;
   logic [3:0]  wv_a;

   byte_lane_mem u_a (
      .clk(clk), .rst_n(rst_n), .wr(wr_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
      .wr_busy(busy_a), .wr_done(done_a), .rd(rd_a), .rd_addr(rd_addr_a), .rd_sel(rd_sel_a),
      .rd_data(rdata_a), .rd_valid(rvalid_a), .rd_err(rerr_a), .word_valid(wv_a),
      .clr_valid(clr_a)
   );

   // Instance B: BYTES_PER_WORD=8, DEPTH=16, BIG_ENDIAN=0
   logic        wr_b, rd_b, clr_b;
   logic [3:0]  wr_addr_b, rd_addr_b;
   logic [2:0]  rd_sel_b;
   logic [63:0] wr_data_b;
   logic        busy_b, done_b, rvalid_b, rerr_b;
   logic [7:0]  rdata_b;
   logic [15:0] wv_b;

   byte_lane_mem #(.BYTES_PER_WORD(8), .DEPTH(16), .BIG_ENDIAN(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .wr(wr_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
      .wr_busy(busy_b), .wr_done(done_b), .rd(rd_b), .rd_addr(rd_addr_b), .rd_sel(rd_sel_b),
      .rd_data(rdata_b), .rd_valid(rvalid_b), .rd_err(rerr_b), .word_valid(wv_b),
      .clr_valid(clr_b)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp_a [4];
   logic [2:0] sel_b [4];
   logic [7:0] exp_b [4];

   initial begin
      exp_a[0] = 8'hA1; exp_a[1] = 8'hB2; exp_a[2] = 8'hC3; exp_a[3] = 8'hD4;
      sel_b[0] = 3'd0;  sel_b[1] = 3'd7;  sel_b[2] = 3'd3;  sel_b[3] = 3'd4;
      exp_b[0] = 8'h88; exp_b[1] = 8'h11; exp_b[2] = 8'h55; exp_b[3] = 8'h44;

      rst_n = 1'b0;
      wr_a = 0; rd_a = 0; clr_a = 0; wr_addr_a = 0; rd_addr_a = 0; rd_sel_a = 0; wr_data_a = 0;
      wr_b = 0; rd_b = 0; clr_b = 0; wr_addr_b = 0; rd_addr_b = 0; rd_sel_b = 0; wr_data_b = 0;
      #3;
      check("rst_busy", 64'(busy_a), 64'h0);
      check("rst_done", 64'(done_a), 64'h0);
      check("rst_rdata", 64'(rdata_a), 64'h0);
      check("rst_rvalid", 64'(rvalid_a), 64'h0);
      check("rst_rerr", 64'(rerr_a), 64'h0);
      check("rst_wv", 64'(wv_a), 64'h0);
      #4 rst_n = 1'b1;
      tick();

      // Write A1B2C3D4 to word 2; a second wr while busy must be ignored
      wr_a = 1; wr_addr_a = 2'd2; wr_data_a = 32'hA1B2C3D4;
      tick();
      check("acc_busy", 64'(busy_a), 64'h1);
      check("acc_done", 64'(done_a), 64'h0);
      check("acc_wv", 64'(wv_a), 64'h0);
      wr_data_a = 32'h11223344;
      tick();
      check("e1_busy", 64'(busy_a), 64'h1);
      tick();
      check("e2_busy", 64'(busy_a), 64'h1);
      tick();
      check("e3_busy", 64'(busy_a), 64'h1);
      check("e3_done", 64'(done_a), 64'h0);
      wr_a = 0;
      tick();
      check("e4_busy", 64'(busy_a), 64'h0);
      check("e4_done", 64'(done_a), 64'h1);
      check("e4_wv", 64'(wv_a), 64'h4);
      tick();
      check("e5_done", 64'(done_a), 64'h0);

      // Read word 2 bytes 0..3
      rd_a = 1; rd_addr_a = 2'd2;
      for (int i = 0; i < 4; i++) begin
         rd_sel_a = 2'(i);
         tick();
         check($sformatf("rd2_data%0d", i), 64'(rdata_a), 64'(exp_a[i]));
         check($sformatf("rd2_valid%0d", i), 64'(rvalid_a), 64'h1);
         check($sformatf("rd2_err%0d", i), 64'(rerr_a), 64'h0);
      end
      rd_a = 0;
      tick();
      check("idle_valid", 64'(rvalid_a), 64'h0);
      check("idle_err", 64'(rerr_a), 64'h0);
      check("idle_hold", 64'(rdata_a), 64'hD4);

      // Read of never-written word 1
      rd_a = 1; rd_addr_a = 2'd1; rd_sel_a = 2'd0;
      tick();
      check("rd1_data", 64'(rdata_a), 64'h0);
      check("rd1_err", 64'(rerr_a), 64'h1);
      check("rd1_valid", 64'(rvalid_a), 64'h0);
      rd_a = 0;

      // Rewrite word 2 while reading it
      wr_a = 1; wr_addr_a = 2'd2; wr_data_a = 32'h55667788;
      tick();
      wr_a = 0; rd_a = 1; rd_addr_a = 2'd2; rd_sel_a = 2'd0;
      tick();
      check("rw_err", 64'(rerr_a), 64'h1);
      check("rw_valid", 64'(rvalid_a), 64'h0);
      tick();
      tick();
      tick();
      check("rw_done", 64'(done_a), 64'h1);
      check("rw_same_edge_err", 64'(rerr_a), 64'h1);
      tick();
      check("rw_after_data", 64'(rdata_a), 64'h55);
      check("rw_after_valid", 64'(rvalid_a), 64'h1);
      rd_a = 0;

      // Back-to-back writes to words 0 and 3
      wr_a = 1; wr_addr_a = 2'd0; wr_data_a = 32'h01020304;
      tick();
      wr_addr_a = 2'd3; wr_data_a = 32'h0A0B0C0D;
      tick();
      tick();
      tick();
      check("bb_busy", 64'(busy_a), 64'h1);
      tick();
      check("bb_done1", 64'(done_a), 64'h1);
      tick();
      check("bb_acc2_done", 64'(done_a), 64'h0);
      check("bb_acc2_busy", 64'(busy_a), 64'h1);
      wr_a = 0;
      tick();
      tick();
      tick();
      check("bb_gap_done", 64'(done_a), 64'h0);
      tick();
      check("bb_done2", 64'(done_a), 64'h1);
      check("bb_wv", 64'(wv_a), 64'hD);
      rd_a = 1; rd_addr_a = 2'd3; rd_sel_a = 2'd3;
      tick();
      check("bb_rd3", 64'(rdata_a), 64'h0D);
      rd_addr_a = 2'd0; rd_sel_a = 2'd0;
      tick();
      check("bb_rd0", 64'(rdata_a), 64'h01);
      rd_a = 0;

      // clr_valid on the completion edge: set wins for the written word
      wr_a = 1; wr_addr_a = 2'd1; wr_data_a = 32'hDEADBEEF;
      tick();
      wr_a = 0;
      tick();
      tick();
      tick();
      clr_a = 1;
      tick();
      check("clr_setwins_done", 64'(done_a), 64'h1);
      check("clr_setwins_wv", 64'(wv_a), 64'h2);
      tick();
      check("clr_all_wv", 64'(wv_a), 64'h0);
      clr_a = 0;

      // Asynchronous reset after two lanes of a write
      wr_a = 1; wr_addr_a = 2'd0; wr_data_a = 32'hCAFEF00D;
      tick();
      wr_a = 0;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(busy_a), 64'h0);
      check("mid_rst_rdata", 64'(rdata_a), 64'h0);
      check("mid_rst_wv", 64'(wv_a), 64'h0);
      #1 rst_n = 1'b1;
      tick();
      check("post_rst_busy", 64'(busy_a), 64'h0);
      tick();
      tick();
      check("post_rst_done", 64'(done_a), 64'h0);
      check("post_rst_wv", 64'(wv_a), 64'h0);
      rd_a = 1; rd_addr_a = 2'd0; rd_sel_a = 2'd0;
      tick();
      check("post_rst_rd_err", 64'(rerr_a), 64'h1);
      rd_a = 0;

      // Instance B: 8-byte little-endian words
      wr_b = 1; wr_addr_b = 4'd9; wr_data_b = 64'h1122334455667788;
      tick();
      wr_b = 0;
      for (int i = 1; i < 8; i++) begin
         tick();
         check($sformatf("b_busy%0d", i), 64'(busy_b), 64'h1);
      end
      tick();
      check("b_done", 64'(done_b), 64'h1);
      check("b_busy_end", 64'(busy_b), 64'h0);
      check("b_wv", 64'(wv_b), 64'h0200);
      rd_b = 1; rd_addr_b = 4'd9;
      for (int i = 0; i < 4; i++) begin
         rd_sel_b = sel_b[i];
         tick();
         check($sformatf("b_rd_data%0d", i), 64'(rdata_b), 64'(exp_b[i]));
         check($sformatf("b_rd_valid%0d", i), 64'(rvalid_b), 64'h1);
      end
      rd_addr_b = 4'd4;
      tick();
      check("b_rd_inv_err", 64'(rerr_b), 64'h1);
      rd_b = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
